program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 7, instruction-memory address width (2^ADDR_W words).
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Load  input  1  single-cycle pulse (debounced key): write SwData as next word.
REQ-006 Start  input  1  single-cycle pulse: release processor to run loaded program.
REQ-007 Clear  input  1  synchronous clear: abort, empty loader, halt processor.
REQ-008 SwData  input  DATA_W  word to load, from board switches.
REQ-009 MemRdData  input  DATA_W  memory read data, valid one cycle after address presented.
REQ-010 MemWrEn  output  1  memory write strobe.
REQ-011 MemAddr  output  ADDR_W  memory address for write and read-back.
REQ-012 MemWrData  output  DATA_W  memory write data.
REQ-013 WordCount  output  ADDR_W+1  number of words loaded.
REQ-014 Run  output  1  high = processor released from hold.
REQ-015 Full  output  1  high when WordCount == 2^ADDR_W.
REQ-016 Error  output  1  sticky read-back mismatch flag.
REQ-017 State  output  3  current FSM state code, for HEX display.

Function
REQ-018 FSM states and codes SHALL be IDLE=0, WRITE=1, READ=2, CHECK=3, RUN=4; State reflects the current state.
REQ-019 IDLE: Load with Full=0 SHALL capture SwData into an internal word register and enter WRITE next cycle.
REQ-020 IDLE: Load with Full=1 SHALL be ignored; no write, no counter change.
REQ-021 Load received in WRITE, READ, CHECK or RUN SHALL be dropped (no queuing).
REQ-022 WRITE: MemWrEn=1 for exactly one cycle, MemAddr=write pointer, MemWrData=captured word.
REQ-023 READ: MemWrEn=0, MemAddr=write pointer; next state CHECK.
REQ-024 CHECK: MemRdData != captured word SHALL set Error; pointer and WordCount increment by 1 regardless; next state IDLE.
REQ-025 Latency: Load sampled at edge n gives MemWrEn high in cycle n+1; WordCount updated after edge n+3 (verify build).
REQ-026 Write pointer SHALL wrap from 2^ADDR_W-1 to 0; WordCount saturates at 2^ADDR_W, asserting Full.
REQ-027 IDLE: Start with WordCount>0 and Error=0 SHALL enter RUN; otherwise Start is ignored.
REQ-028 Load and Start in the same IDLE cycle: Load SHALL win, Start dropped.
REQ-029 RUN: Run=1, MemWrEn=0; leave RUN only on Clear or Reset.
REQ-030 Clear SHALL have highest priority in every state: next state IDLE, pointer=0, WordCount=0, Error=0, Run=0; an in-progress write not yet strobed is abandoned.
REQ-031 MemWrEn SHALL be 0 in every state except WRITE.

Reset
REQ-032 Reset low SHALL immediately force State=IDLE, MemWrEn=0, MemAddr=0, MemWrData=0, WordCount=0, Run=0, Full=0, Error=0, captured word=0.
REQ-033 Reset asserted mid-WRITE SHALL deassert MemWrEn asynchronously; no partial count update.
REQ-034 After Reset release, first Load SHALL write address 0.

Configuration
REQ-035 Macro LOADER_VERIFY_EN defined: read-back verification active per REQ-023/024.
REQ-036 LOADER_VERIFY_EN undefined: READ and CHECK not built; WRITE increments pointer/WordCount and returns to IDLE; Error tied 0; WordCount updated after edge n+1.

Verification
REQ-037 Reset, Load SwData=16'h1234 -> one MemWrEn pulse, MemAddr=0, MemWrData=16'h1234; WordCount=1, State back to 0.
REQ-038 Load 128 words with ADDR_W=7 -> Full=1, WordCount=128; 129th Load -> no MemWrEn pulse, counts unchanged.
REQ-039 Verify build, memory model corrupts read of address 3 -> Error=1 after 4th word; Start ignored, Run=0; Clear -> Error=0, WordCount=0.
REQ-040 Load 2 words, Start -> State=4, Run=1; further Load -> no MemWrEn; Clear -> Run=0, State=0.
REQ-041 Load and Start same cycle in IDLE, WordCount=1 -> write occurs, State=1, Run stays 0.
REQ-042 Reset pulsed low during WRITE -> MemWrEn drops immediately, all outputs at reset values; next Load writes address 0.

Source files
------------

// File: rtl/program_loader.sv
// Loads switch words into instruction memory one per Load pulse, then releases the processor on Start.
// Define LOADER_VERIFY_EN to add a read-back check of every written word (READ/CHECK states).
module program_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_sw_data,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_run,
  output logic              o_full,
  output logic              o_error,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic [DATA_W-1:0]   r_word;
  logic                r_wr_en;
  logic                r_run;
  logic                r_error;

  logic                w_full;
  logic [ADDR_W:0]     w_count_inc;

  assign w_full      = (r_count == CNT_FULL);
  assign w_count_inc = w_full ? r_count : (r_count + CNT_ONE);

  // Loader FSM; Clear overrides every state and abandons any write not yet strobed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= PTR_ZERO;
      r_count <= CNT_ZERO;
      r_word  <= {DATA_W{1'b0}};
      r_wr_en <= 1'b0;
      r_run   <= 1'b0;
      r_error <= 1'b0;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_ptr   <= PTR_ZERO;
      r_count <= CNT_ZERO;
      r_wr_en <= 1'b0;
      r_run   <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wr_en <= 1'b0;
          r_run   <= 1'b0;
          if (i_load && !w_full) begin
            r_word  <= i_sw_data;
            r_wr_en <= 1'b1;
            r_state <= S_WRITE;
          end else if (i_start && !i_load && (r_count != CNT_ZERO) && !r_error) begin
            r_run   <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
`ifdef LOADER_VERIFY_EN
          r_state <= S_READ;
`else
          r_ptr   <= r_ptr + PTR_ONE;
          r_count <= w_count_inc;
          r_state <= S_IDLE;
`endif
        end
`ifdef LOADER_VERIFY_EN
        S_READ: begin
          r_wr_en <= 1'b0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_wr_en <= 1'b0;
          if (i_mem_rd_data != r_word) begin
            r_error <= 1'b1;
          end else begin
            r_error <= r_error;
          end
          r_ptr   <= r_ptr + PTR_ONE;
          r_count <= w_count_inc;
          r_state <= S_IDLE;
        end
`endif
        S_RUN: begin
          r_wr_en <= 1'b0;
          r_run   <= 1'b1;
          r_state <= S_RUN;
        end
        default: begin
          r_wr_en <= 1'b0;
          r_run   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_wr_en   = r_wr_en;
  assign o_mem_addr    = r_ptr;
  assign o_mem_wr_data = r_word;
  assign o_word_count  = r_count;
  assign o_run         = r_run;
  assign o_full        = w_full;
  assign o_state       = r_state;

`ifdef LOADER_VERIFY_EN
  assign o_error = r_error;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{i_mem_rd_data, r_error};
  assign o_error     = 1'b0;
`endif

endmodule
